// File: rtl/room_draw_scheduler.sv
// room_draw_scheduler: shares the VGA plot path between five room tiles
// and a full-screen clear; round-robin room grants, sticky requests.
//
// Ports:
//   clock       system clock
//   reset       asynchronous active-low reset
//   room_req    per-room one-cycle update pulse (bit i = room i)
//   room_state  per-room ON(1)/OFF(0) level, sampled when a room is granted
//   funct       1 = LIGHT colour map, 0 = DOOR colour map
//   clear_req   clear-screen pulse
//   x, y        pixel coordinate (held when plot=0)
//   colour      pixel colour (held when plot=0)
//   plot        pixel write strobe
//   busy        high whenever the scheduler is not idle
//   grant       one-hot room being drawn, 0 outside a tile
//   frame_done  one-cycle pulse after the last pixel of a tile or clear
//
// Build option: define ROOM_FRAME_EN for 6x6 tiles with a white border
// around the 4x4 state-coloured centre.

module room_draw_scheduler #(
   parameter int MAX_X_PIXELS = 160,
   parameter int MAX_Y_PIXELS = 120,
   parameter int ROOM_Y       = 56,
   parameter int ROOM_X0      = 8,
   parameter int ROOM_PITCH   = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] room_req,
   input  logic [4:0] room_state,
   input  logic       funct,
   input  logic       clear_req,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic [4:0] grant,
   output logic       frame_done
);

`ifdef ROOM_FRAME_EN
   localparam int TILE = 6;
`else
   localparam int TILE = 4;
`endif

   localparam logic [2:0] OFS_LAST = 3'(TILE - 1);
   localparam logic [7:0] X_LAST   = 8'(MAX_X_PIXELS - 1);
   localparam logic [6:0] Y_LAST   = 7'(MAX_Y_PIXELS - 1);
   localparam logic [6:0] Y_BASE   = 7'(ROOM_Y);

   typedef enum logic [1:0] {
      IDLE,
      PICK,
      DRAW,
      CLEAR
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [4:0] pending;
   logic [4:0] pending_nxt;
   logic       clear_pending;
   logic       clear_pending_nxt;
   logic [2:0] rr;
   logic [2:0] ox;
   logic [2:0] oy;
   logic [2:0] ox_nxt;
   logic [2:0] oy_nxt;
   logic [2:0] snap;
   logic [7:0] base_x;
   logic [2:0] pick_idx;
   logic       pick_found;
   logic [2:0] pick_colour;
   logic [2:0] first_colour;
   logic [2:0] pix_colour;
   logic       tile_last;
   logic       clear_last;
   logic       enter_clear;
   int         pick_j;

   function automatic logic [2:0] state_colour(
      input logic on,
      input logic light
   );
      logic [2:0] c;
      unique case ({light, on})
         2'b11:   c = 3'b110;
         2'b10:   c = 3'b001;
         2'b01:   c = 3'b010;
         default: c = 3'b100;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] room_x(input logic [2:0] idx);
      return 8'(ROOM_X0 + int'(idx) * ROOM_PITCH);
   endfunction

   // First pending room at or after the round-robin pointer, wrapping 4->0.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_j     = 0;
      for (int k = 0; k < 5; k++) begin
         pick_j = int'(rr) + k;
         if (pick_j >= 5) pick_j = pick_j - 5;
         if (!pick_found && pending[3'(pick_j)]) begin
            pick_found = 1'b1;
            pick_idx   = 3'(pick_j);
         end
      end
   end

   assign pick_colour = state_colour(room_state[pick_idx], funct);

`ifdef ROOM_FRAME_EN
   assign first_colour = 3'b111;
`else
   assign first_colour = pick_colour;
`endif

   always_comb begin
      ox_nxt = ox + 3'd1;
      oy_nxt = oy;
      if (ox == OFS_LAST) begin
         ox_nxt = '0;
         oy_nxt = oy + 3'd1;
      end
   end

   always_comb begin
      pix_colour = snap;
`ifdef ROOM_FRAME_EN
      if (ox_nxt == '0 || ox_nxt == OFS_LAST ||
          oy_nxt == '0 || oy_nxt == OFS_LAST)
         pix_colour = 3'b111;
`endif
   end

   assign tile_last  = (state == DRAW) &&
                       (ox == OFS_LAST) && (oy == OFS_LAST);
   assign clear_last = (state == CLEAR) &&
                       (x == X_LAST) && (y == Y_LAST);

   // A request arriving on the final tile cycle keeps its bit set.
   always_comb begin
      pending_nxt = pending | room_req;
      if (tile_last) pending_nxt = (pending & ~grant) | room_req;
      if (clear_last) pending_nxt = 5'h1f;
   end

   assign enter_clear = (state_nxt == CLEAR) && (state != CLEAR);
   assign clear_pending_nxt = (clear_pending & ~enter_clear) | clear_req;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (clear_pending)  state_nxt = CLEAR;
            else if (|pending)  state_nxt = PICK;
         end
         PICK: begin
            if (clear_pending)   state_nxt = CLEAR;
            else if (pick_found) state_nxt = DRAW;
            else                 state_nxt = IDLE;
         end
         DRAW: begin
            if (tile_last) begin
               if (clear_pending)     state_nxt = CLEAR;
               else if (|pending_nxt) state_nxt = PICK;
               else                   state_nxt = IDLE;
            end
         end
         CLEAR: begin
            if (clear_last) state_nxt = PICK;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   assign busy = (state != IDLE);

   // Output registers carry the pixel being plotted; during CLEAR the
   // x/y registers double as the raster counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending       <= '0;
         clear_pending <= 1'b0;
         rr            <= '0;
         ox            <= '0;
         oy            <= '0;
         snap          <= '0;
         base_x        <= '0;
         x             <= '0;
         y             <= '0;
         colour        <= '0;
         plot          <= 1'b0;
         grant         <= '0;
         frame_done    <= 1'b0;
      end else begin
         pending       <= pending_nxt;
         clear_pending <= clear_pending_nxt;
         frame_done    <= tile_last | clear_last;
         unique case (state)
            PICK: begin
               if (state_nxt == DRAW) begin
                  grant  <= 5'b00001 << pick_idx;
                  rr     <= (pick_idx == 3'd4) ? 3'd0 : pick_idx + 3'd1;
                  snap   <= pick_colour;
                  base_x <= room_x(pick_idx);
                  ox     <= '0;
                  oy     <= '0;
                  x      <= room_x(pick_idx);
                  y      <= Y_BASE;
                  colour <= first_colour;
                  plot   <= 1'b1;
               end
            end
            DRAW: begin
               if (tile_last) begin
                  grant <= '0;
                  plot  <= 1'b0;
               end else begin
                  ox     <= ox_nxt;
                  oy     <= oy_nxt;
                  x      <= base_x + 8'(ox_nxt);
                  y      <= Y_BASE + 7'(oy_nxt);
                  colour <= pix_colour;
               end
            end
            CLEAR: begin
               if (clear_last) begin
                  plot <= 1'b0;
                  rr   <= '0;
               end else if (x == X_LAST) begin
                  x <= '0;
                  y <= y + 7'd1;
               end else begin
                  x <= x + 8'd1;
               end
            end
            default: ;
         endcase
         if (enter_clear) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b1;
         end
      end
   end

endmodule
